// File: rtl/risc16_trace_buffer_if.sv
// Bus bundle between the RiSC-16 retire tap / trace consumer and the trace buffer.
// The master side drives retire, trigger and control signals; the slave side returns readout and status.
interface risc16_trace_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
);
  localparam int ENTRY_W = 3 * DATA_W + 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               arm;
  logic               retire_valid;
  logic [DATA_W-1:0]  retire_pc;
  logic [DATA_W-1:0]  retire_instr;
  logic               retire_we;
  logic [2:0]         retire_waddr;
  logic [DATA_W-1:0]  retire_wdata;
  logic               trig_en;
  logic [DATA_W-1:0]  trig_pc;
  logic               force_trig;
  logic               rd_ready;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_last;
  logic               armed;
  logic               triggered;
  logic               done;
  logic [CNT_W-1:0]   trig_pos;

  modport master (
    output arm, retire_valid, retire_pc, retire_instr, retire_we, retire_waddr, retire_wdata,
           trig_en, trig_pc, force_trig, rd_ready,
    input  rd_valid, rd_data, rd_last, armed, triggered, done, trig_pos
  );

  modport slave (
    input  arm, retire_valid, retire_pc, retire_instr, retire_we, retire_waddr, retire_wdata,
           trig_en, trig_pc, force_trig, rd_ready,
    output rd_valid, rd_data, rd_last, armed, triggered, done, trig_pos
  );
endinterface

// File: rtl/risc16_trace_buffer.sv
// Trigger-based retirement trace buffer for RiSC-16: circular capture, post-trigger stop,
// then oldest-first readout over a valid/ready port with a one-entry prefetch.
module risc16_trace_buffer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 32,
  parameter int POST_CNT = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  risc16_trace_buffer_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 3 * DATA_W + 4;
  localparam logic [CNT_W-1:0] POST_INIT = CNT_W'(POST_CNT);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_POST, S_DONE, S_READ} state_t;

  state_t             state, state_next;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, oldest;
  logic [CNT_W-1:0]   stored, stored_inc, post_left, rd_cnt, trig_pos_q;
  logic [ENTRY_W-1:0] rd_data_q;
  logic               rd_valid_q, rd_last_q;
  logic               capture, trig_hit, restart, rd_fire, post_end, pc_match;

  assign pc_match   = bus.trig_en && bus.retire_valid && (bus.retire_pc == bus.trig_pc);
  assign stored_inc = (stored == FULL) ? stored : stored + CNT_W'(1);
  assign oldest     = wr_ptr - stored[PTR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    trig_hit   = 1'b0;
    restart    = 1'b0;
    rd_fire    = 1'b0;
    post_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.arm) begin
          restart    = 1'b1;
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (bus.arm) begin
          restart = 1'b1;
        end else begin
          capture = bus.retire_valid;
          if (bus.force_trig || pc_match) begin
            trig_hit = 1'b1;
            // The trigger-cycle entry counts as the first post entry, so POST_CNT=1 ends here
            if (bus.retire_valid && POST_INIT == CNT_W'(1)) begin
              post_end   = 1'b1;
              state_next = S_DONE;
            end else begin
              state_next = S_POST;
            end
          end
        end
      end
      S_POST: begin
        if (bus.arm) begin
          restart    = 1'b1;
          state_next = S_ARMED;
        end else begin
          capture = bus.retire_valid;
          if (bus.retire_valid && post_left == CNT_W'(1)) begin
            post_end   = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: state_next = S_READ;
      S_READ: begin
        if (rd_valid_q && bus.rd_ready) begin
          rd_fire = 1'b1;
          if (rd_last_q) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && capture)
      mem[wr_ptr] <= {bus.retire_pc, bus.retire_instr, bus.retire_we, bus.retire_waddr, bus.retire_wdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      stored     <= '0;
      post_left  <= '0;
      trig_pos_q <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      if (restart || state == S_IDLE) begin
        wr_ptr    <= '0;
        stored    <= '0;
        post_left <= '0;
      end else begin
        if (capture) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          stored <= stored_inc;
        end
        if (trig_hit)
          post_left <= bus.retire_valid ? POST_INIT - CNT_W'(1) : POST_INIT;
        else if (state == S_POST && capture)
          post_left <= post_left - CNT_W'(1);
      end

      if (restart)       trig_pos_q <= '0;
      else if (post_end) trig_pos_q <= stored_inc - POST_INIT;

      // Readout keeps the next entry already loaded so back-to-back handshakes have no bubble
      if (state == S_DONE) begin
        rd_data_q  <= mem[oldest];
        rd_ptr     <= oldest + PTR_W'(1);
        rd_cnt     <= '0;
        rd_valid_q <= 1'b1;
        rd_last_q  <= (stored == CNT_W'(1));
      end else if (rd_fire) begin
        if (rd_last_q) begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
        end else begin
          rd_data_q <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + PTR_W'(1);
          rd_cnt    <= rd_cnt + CNT_W'(1);
          rd_last_q <= (rd_cnt + CNT_W'(2) == stored);
        end
      end
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.armed     = (state == S_ARMED);
  assign bus.triggered = (state == S_POST);
  assign bus.done      = (state == S_DONE) || (state == S_READ);
  assign bus.trig_pos  = trig_pos_q;
endmodule

// File: doc/risc16_trace_buffer.md
# risc16_trace_buffer

Parametrised on-chip retirement trace buffer for the RiSC-16 processor. It records one entry per retired instruction (PC, instruction word, register write-back) into a circular buffer. Capture stops a programmable number of entries after a trigger, and the trace is then streamed out oldest-first over a valid/ready port. It sits beside `risc16_processor` and taps its retire signals, replacing printf-style monitoring with a synthesizable, trigger-based capture.

## Interface
Parameters:
- `DATA_W`, 16: width of PC, instruction and write-back data.
- `DEPTH`, 32: entries stored; power of two, ≥ 4.
- `POST_CNT`, 16: entries captured from the trigger onward; 1..DEPTH.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `arm` in 1: pulse; clears the buffer and starts capture.
- `retire_valid` in 1: one instruction retires this cycle.
- `retire_pc` in DATA_W: PC of the retiring instruction.
- `retire_instr` in DATA_W: instruction word.
- `retire_we` in 1: register-file write enable.
- `retire_waddr` in 3: destination register.
- `retire_wdata` in DATA_W: write-back value.
- `trig_en` in 1: enable the PC-match trigger.
- `trig_pc` in DATA_W: trigger PC.
- `force_trig` in 1: unconditional trigger.
- `rd_ready` in 1: consumer accepts `rd_data`.
- `rd_valid` out 1: `rd_data` holds a valid entry.
- `rd_data` out 3*DATA_W+4: `{pc, instr, we, waddr, wdata}`, MSB first.
- `rd_last` out 1: current entry is the final one.
- `armed` out 1: capturing, waiting for the trigger.
- `triggered` out 1: trigger seen, post-capture in progress.
- `done` out 1: capture complete, trace available or being read.
- `trig_pos` out log2(DEPTH)+1: index in readout order of the first post-trigger entry.

## Operation
- States: IDLE → ARMED → POST → DONE → READ → IDLE.
- IDLE:
  - `arm` → ARMED.
  - `wr_ptr`, `stored` and `post_left` are cleared.
- Capture, in ARMED and POST:
  - Each `retire_valid` cycle writes an entry at `wr_ptr`.
  - `wr_ptr` increments mod DEPTH.
  - `stored` saturates at DEPTH; older entries are overwritten on wrap.
- Trigger in ARMED: `force_trig`, or `trig_en && retire_valid && retire_pc == trig_pc`.
  - Go to POST with `post_left = POST_CNT`.
  - A retiring instruction in the trigger cycle is stored and counted as the first post entry.
  - PC match without `retire_valid` is ignored.
- POST:
  - Each stored entry decrements `post_left`.
  - When the last post entry is written → DONE.
  - `trig_pos = stored_final − POST_CNT`.
  - Further triggers are ignored.
- DONE lasts one cycle: prefetch the oldest entry, at `(wr_ptr − stored) mod DEPTH`, then → READ.
- READ:
  - `rd_valid = 1`.
  - On `rd_valid && rd_ready`, advance to the next entry; it is presented on the following cycle with no bubble (prefetched read).
  - `rd_last = 1` on entry `stored − 1`.
  - Handshake on the last entry → IDLE, with `done` and `rd_valid` low.
- `arm` in ARMED or POST restarts capture: counters cleared, state ARMED. `arm` wins over a same-cycle trigger.
- `arm` in DONE or READ is ignored.
- `rd_ready` is ignored when `rd_valid = 0`.
- `retire_*` inputs are ignored in IDLE, DONE and READ.
- `done = 1` in DONE and READ.

## Timing
- Reset:
  - Affects state, pointers, counters, status bits and `rd_*` outputs only; storage contents are left untouched.
  - Reset values: state IDLE; `rd_valid`, `rd_last`, `armed`, `triggered`, `done` = 0; `rd_data` = 0; `trig_pos` = 0.
  - Reset mid-capture or mid-readout aborts immediately: IDLE on the next edge.
- `armed` rises the cycle after the `arm` edge.
- Capture write latency: entry written at the edge where `retire_valid` is sampled. One entry per cycle sustained.
- `triggered` rises the cycle after the trigger edge.
- After the edge writing the final post entry: `done` at +1, `rd_valid` at +2.
- Readout: one entry per cycle while `rd_ready` is held high. `rd_data` stays stable while `rd_valid && !rd_ready`.

## Test plan
Parameters for all scenarios: DEPTH=8, POST_CNT=4.

- **Underfill.** Arm; retire PCs 0..5; `force_trig` with PC 2.
  - Expected: 3 post entries plus the trigger entry = PCs 2..5; capture stops.
  - `stored = 6`, `trig_pos = 2`.
  - Readout PCs 0..5; `rd_last` on PC 5.
- **Wrap.** Arm; retire PCs 0..19; `trig_en` with `trig_pc = 12`.
  - Expected: readout PCs 8..15, `trig_pos = 4`.
  - PCs 16..19 are not stored.
- **Backpressure.** Toggle `rd_ready` 1,0,0,1,…
  - Expected: `rd_data` holds during stalls.
  - Every entry is delivered exactly once, in order, with no gaps.
- **Sparse valid / trigger gating.** `retire_pc = trig_pc` while `retire_valid = 0`.
  - Expected: no trigger.
  - A gap cycle between valid retires does not advance the pointer.
- **Re-arm and trigger race.** `arm` in the same cycle as a PC-match trigger in ARMED.
  - Expected: state stays ARMED and `stored = 0`.
  - `arm` during READ is ignored; readout completes.
- **Reset mid-readout.** `rst_n = 0` for 1 cycle after 3 handshakes.
  - Expected: all outputs return to their reset values on the next edge.
  - A subsequent arm/capture behaves as after power-up.
